// File: rtl/line_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : line_cmd_pkg                                               |
// | Description : Shared constants and types for the line command queue:     |
// |               CPU register offsets, STATUS/CTRL bit positions, the       |
// |               sequencer state encoding and the queued command layout.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package line_cmd_pkg;

    // CPU word offsets
    localparam logic [2:0] c_REG_COLOR  = 3'd0;
    localparam logic [2:0] c_REG_X0     = 3'd1;
    localparam logic [2:0] c_REG_Y0     = 3'd2;
    localparam logic [2:0] c_REG_X1     = 3'd3;
    localparam logic [2:0] c_REG_Y1     = 3'd4;
    localparam logic [2:0] c_REG_GO     = 3'd5;
    localparam logic [2:0] c_REG_CTRL   = 3'd6;
    localparam logic [2:0] c_REG_STATUS = 3'd7;

    // STATUS bit positions (count occupies [7:0])
    localparam int c_STAT_FULL  = 8;
    localparam int c_STAT_EMPTY = 9;
    localparam int c_STAT_OVF   = 10;
    localparam int c_STAT_BUSY  = 11;

    // CTRL bit positions
    localparam int c_CTRL_CLR_OVF = 0;
    localparam int c_CTRL_FLUSH   = 1;

    // Sequencer state encoding
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t c_S_IDLE  = 3'd0;
    localparam seq_state_t c_S_COLOR = 3'd1;
    localparam seq_state_t c_S_X0    = 3'd2;
    localparam seq_state_t c_S_Y0    = 3'd3;
    localparam seq_state_t c_S_X1    = 3'd4;
    localparam seq_state_t c_S_Y1    = 3'd5;
    localparam seq_state_t c_S_TRIG  = 3'd6;
    localparam seq_state_t c_S_HOLD  = 3'd7;

    // One complete line command, 64 bits
    typedef struct packed {
        logic [23:0] color;
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  y1;
    } line_entry_t;

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmd_fifo                                                   |
// | Description : Synchronous FIFO with show-ahead output (dout is the head  |
// |               entry whenever empty is low).                              |
// |   clk, rst      clock, asynchronous active-high reset                    |
// |   push, din     write request and data; ignored when full                |
// |   pop           read request; ignored when empty                         |
// |   flush         discards every entry still queued after this cycle       |
// |   dout          head entry                                               |
// |   count/full/empty  occupancy flags                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cmd_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full/empty are judged on the state at the start of the cycle, so a
    // pop in the same cycle never makes room for a push into a full FIFO.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // The head popped this cycle has already left through dout,
            // so jumping the read pointer to the write pointer only drops
            // entries that were still waiting.
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign count = r_wr_ptr - r_rd_ptr;
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/line_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : line_cmd_queue                                             |
// | Description : CPU command port, command FIFO and sequencer feeding the   |
// |               line engine. Software stages colour and endpoints, writes  |
// |               GO to queue a line; the sequencer replays each command as  |
// |               colour/x0/y0/x1/y1 strobes followed by a trigger pulse.    |
// |   clk, rst                  clock, asynchronous active-high reset        |
// |   cpu_addr/din/we/re/dout   register port (dout registered)              |
// |   busy                      sequencer active or FIFO not empty           |
// |   LE_ready                  engine idle, sampled only when idle          |
// |   LE_color, LE_point        colour and coordinate buses                  |
// |   LE_*_valid, LE_trigger    one-cycle strobes                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module line_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_dout,
    output logic        busy,
    input  logic        LE_ready,
    output logic [31:0] LE_color,
    output logic [9:0]  LE_point,
    output logic        LE_color_valid,
    output logic        LE_x0_valid,
    output logic        LE_y0_valid,
    output logic        LE_x1_valid,
    output logic        LE_y1_valid,
    output logic        LE_trigger
);

    import line_cmd_pkg::*;

    logic [23:0] r_color;
    logic [9:0]  r_x0, r_y0, r_x1, r_y1;
    logic        r_overflow;
    line_entry_t r_cmd;
    seq_state_t  r_state, w_next;

    logic        w_go, w_flush, w_pop;
    logic        w_full, w_empty, w_busy;
    logic [AW:0] w_count;
    line_entry_t w_push_entry, w_head;
    logic [31:0] w_status, w_rdata;
    logic        w_unused;

    // Upper data bits have no home in any register.
    assign w_unused = ^cpu_din[31:24];

    assign w_go    = cpu_we && (cpu_addr == c_REG_GO);
    assign w_flush = cpu_we && (cpu_addr == c_REG_CTRL) && cpu_din[c_CTRL_FLUSH];
    assign w_pop   = (r_state == c_S_IDLE) && !w_empty && LE_ready;
    assign w_busy  = (r_state != c_S_IDLE) || !w_empty;
    assign busy    = w_busy;

    assign w_push_entry = '{color: r_color, x0: r_x0, y0: r_y0, x1: r_x1, y1: r_y1};

    cmd_fifo #(
        .WIDTH ($bits(line_entry_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_go),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_push_entry),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Staged registers and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_color    <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_overflow <= 1'b0;
        end else if (cpu_we) begin
            case (cpu_addr)
                c_REG_COLOR: r_color <= cpu_din[23:0];
                c_REG_X0:    r_x0    <= cpu_din[9:0];
                c_REG_Y0:    r_y0    <= cpu_din[9:0];
                c_REG_X1:    r_x1    <= cpu_din[9:0];
                c_REG_Y1:    r_y1    <= cpu_din[9:0];
                c_REG_GO:    if (w_full) r_overflow <= 1'b1;
                c_REG_CTRL:  if (cpu_din[c_CTRL_CLR_OVF]) r_overflow <= 1'b0;
                default:     ;
            endcase
        end
    end

    // Read path
    always_comb begin
        w_status              = '0;
        w_status[AW:0]        = w_count;
        w_status[c_STAT_FULL] = w_full;
        w_status[c_STAT_EMPTY]= w_empty;
        w_status[c_STAT_OVF]  = r_overflow;
        w_status[c_STAT_BUSY] = w_busy;
    end

    always_comb begin
        w_rdata = '0;
        case (cpu_addr)
            c_REG_COLOR:  w_rdata[23:0] = r_color;
            c_REG_X0:     w_rdata[9:0]  = r_x0;
            c_REG_Y0:     w_rdata[9:0]  = r_y0;
            c_REG_X1:     w_rdata[9:0]  = r_x1;
            c_REG_Y1:     w_rdata[9:0]  = r_y1;
            c_REG_STATUS: w_rdata       = w_status;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_dout <= '0;
        end else if (cpu_re) begin
            cpu_dout <= w_rdata;
        end
    end

    // Sequencer: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sequencer: next state
    always_comb begin
        w_next = c_S_IDLE;
        case (r_state)
            c_S_IDLE:  w_next = w_pop ? c_S_COLOR : c_S_IDLE;
            c_S_COLOR: w_next = c_S_X0;
            c_S_X0:    w_next = c_S_Y0;
            c_S_Y0:    w_next = c_S_X1;
            c_S_X1:    w_next = c_S_Y1;
            c_S_Y1:    w_next = c_S_TRIG;
            c_S_TRIG:  w_next = c_S_HOLD;
            default:   w_next = c_S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe is high
    // during exactly the cycle the sequencer spends in its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd          <= '0;
            LE_point       <= '0;
            LE_color_valid <= 1'b0;
            LE_x0_valid    <= 1'b0;
            LE_y0_valid    <= 1'b0;
            LE_x1_valid    <= 1'b0;
            LE_y1_valid    <= 1'b0;
            LE_trigger     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cmd <= w_head;
            end
            LE_color_valid <= (w_next == c_S_COLOR);
            LE_x0_valid    <= (w_next == c_S_X0);
            LE_y0_valid    <= (w_next == c_S_Y0);
            LE_x1_valid    <= (w_next == c_S_X1);
            LE_y1_valid    <= (w_next == c_S_Y1);
            LE_trigger     <= (w_next == c_S_TRIG);
            case (w_next)
                c_S_X0:  LE_point <= r_cmd.x0;
                c_S_Y0:  LE_point <= r_cmd.y0;
                c_S_X1:  LE_point <= r_cmd.x1;
                c_S_Y1:  LE_point <= r_cmd.y1;
                default: LE_point <= '0;
            endcase
        end
    end

    // The holding register loads at the pop edge, so its colour field is
    // already a flop output that holds until the next command.
    assign LE_color = {8'h00, r_cmd.color};

endmodule
`default_nettype wire

// File: tb/tb_line_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_line_cmd_queue                                          |
// | Description : Self-checking bench for line_cmd_queue. Commands are       |
// |               queued as expectations when GO is written and consumed by  |
// |               a monitor that follows the strobe sequence.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_line_cmd_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cpu_addr;
    logic [31:0] cpu_din;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_dout;
    logic        busy;
    logic        LE_ready;
    logic [31:0] LE_color;
    logic [9:0]  LE_point;
    logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger;

    typedef struct {
        logic [31:0] color;
        logic [9:0]  x0, y0, x1, y1;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   mon_rd = 0;
    int   mon_phase = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t_go = 0;
    int   t_color = -1;
    int   t_trig = -1000;
    int   drop_cnt = 0;
    int   abort_req = 0;
    int   abort_seen = 0;
    bit   ready_req = 1'b0;
    bit   drop_mode = 1'b0;

    assign LE_ready = ready_req && (drop_cnt == 0);

    line_cmd_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_we         (cpu_we),
        .cpu_re         (cpu_re),
        .cpu_dout       (cpu_dout),
        .busy           (busy),
        .LE_ready       (LE_ready),
        .LE_color       (LE_color),
        .LE_point       (LE_point),
        .LE_color_valid (LE_color_valid),
        .LE_x0_valid    (LE_x0_valid),
        .LE_y0_valid    (LE_y0_valid),
        .LE_x1_valid    (LE_x1_valid),
        .LE_y1_valid    (LE_y1_valid),
        .LE_trigger     (LE_trigger)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Monitor: follows each command through its strobes
    always @(negedge clk) begin
        int n;
        if (abort_seen != abort_req) begin
            abort_seen = abort_req;
            mon_phase  = 0;
        end
        n = $countones({LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger});
        if (!rst) begin
            if (drop_cnt > 0) drop_cnt--;
            if (n > 1) chk("one_strobe", n, 1);
            case (mon_phase)
                0: begin
                    chk("point_idle", LE_point, 0);
                    if (LE_color_valid) begin
                        if (mon_rd < exp_q.size()) begin
                            cur = exp_q[mon_rd];
                            mon_rd++;
                            chk("color", LE_color, cur.color);
                            if (drop_mode) chk("ready_gap", (cyc - t_trig) > 20, 1);
                            t_color   = cyc;
                            mon_phase = 1;
                        end else begin
                            chk("unexpected_color", LE_color_valid, 0);
                        end
                    end else if (n != 0) begin
                        chk("stray_strobe", n, 0);
                    end
                end
                1: begin chk("x0_valid", LE_x0_valid, 1); chk("x0", LE_point, cur.x0); mon_phase = 2; end
                2: begin chk("y0_valid", LE_y0_valid, 1); chk("y0", LE_point, cur.y0); mon_phase = 3; end
                3: begin chk("x1_valid", LE_x1_valid, 1); chk("x1", LE_point, cur.x1); mon_phase = 4; end
                4: begin chk("y1_valid", LE_y1_valid, 1); chk("y1", LE_point, cur.y1); mon_phase = 5; end
                default: begin
                    chk("trigger", LE_trigger, 1);
                    chk("point_trig", LE_point, 0);
                    t_trig = cyc;
                    if (drop_mode) drop_cnt = 20;
                    mon_phase = 0;
                end
            endcase
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        cpu_addr = a; cpu_re = 1'b1;
        @(posedge clk); #1;
        cpu_re = 1'b0;
        d = cpu_dout;
    endtask

    task automatic send_line(input logic [31:0] c, x0, y0, x1, y1, input bit expect_it);
        exp_t e;
        cpu_write(3'd0, c);
        cpu_write(3'd1, x0);
        cpu_write(3'd2, y0);
        cpu_write(3'd3, x1);
        cpu_write(3'd4, y1);
        if (expect_it) begin
            e.color = c & 32'h00FF_FFFF;
            e.x0 = x0[9:0]; e.y0 = y0[9:0]; e.x1 = x1[9:0]; e.y1 = y1[9:0];
            exp_q.push_back(e);
        end
        t_go = cyc;
        cpu_write(3'd5, 32'h0);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (!(mon_rd == exp_q.size() && mon_phase == 0 && !busy && drop_cnt == 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drained", k < budget, 1);
    endtask

    task automatic wait_strobe(input int which, input int budget);
        int k = 0;
        @(negedge clk);
        while (!((which == 0) ? LE_color_valid : LE_x1_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("saw_strobe", k < budget, 1);
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_color", LE_color, 0);
        chk("rst_dout", cpu_dout, 0);
        chk("rst_busy", busy, 0);
        cpu_read(3'd7, rd); chk("rst_status", rd, 32'h200);

        // Single line with latency
        ready_req = 1'b1;
        send_line(32'h00FF8040, 10, 20, 100, 50, 1'b1);
        wait_drain(100);
        chk("lat_color", t_color - t_go, 2);
        chk("lat_trig", t_trig - t_go, 7);

        // Truncation of staged fields
        send_line(32'hAB123456, 32'hFFFFF3FF, 32'h15, 32'h2A, 32'h3FF, 1'b1);
        cpu_read(3'd1, rd); chk("rd_x0_trunc", rd, 32'h3FF);
        cpu_read(3'd0, rd); chk("rd_color_trunc", rd, 32'h00123456);
        cpu_read(3'd6, rd); chk("rd_ctrl_zero", rd, 0);
        wait_drain(100);

        // Backpressure, then ready model that drops after each trigger
        ready_req = 1'b0;
        send_line(32'h111111, 1, 2, 3, 4, 1'b1);
        send_line(32'h222222, 5, 6, 7, 8, 1'b1);
        repeat (5) @(posedge clk); #1;
        cpu_read(3'd7, rd); chk("bp_status", rd, 32'h802);
        chk("bp_none_popped", mon_rd, exp_q.size() - 2);
        drop_mode = 1'b1;
        ready_req = 1'b1;
        wait_drain(300);
        drop_mode = 1'b0;

        // Overflow and sticky flag clearing
        ready_req = 1'b0;
        send_line(32'h333333, 9, 9, 9, 9, 1'b0);
        repeat (4) cpu_write(3'd5, 32'h0);
        cpu_read(3'd7, rd); chk("ovf_status", rd, 32'hD04);
        cpu_write(3'd7, 32'hFFFF_FFFF);
        cpu_write(3'd6, 32'h1);
        cpu_read(3'd7, rd); chk("ovf_cleared", rd, 32'h904);
        cpu_write(3'd6, 32'h2);
        cpu_read(3'd7, rd); chk("flush_idle", rd, 32'h200);
        ready_req = 1'b1;
        repeat (20) @(posedge clk); #1;

        // Flush while the first of three sequences is in flight
        ready_req = 1'b0;
        send_line(32'h0A0B0C, 11, 12, 13, 14, 1'b1);
        send_line(32'h0D0E0F, 21, 22, 23, 24, 1'b0);
        send_line(32'h101112, 31, 32, 33, 34, 1'b0);
        cpu_read(3'd7, rd); chk("three_queued", rd, 32'h803);
        ready_req = 1'b1;
        wait_strobe(0, 50);
        @(posedge clk); #1;
        chk("flush_at_x0", LE_x0_valid, 1);
        cpu_write(3'd6, 32'h2);
        wait_drain(100);
        cpu_read(3'd7, rd); chk("after_flush", rd, 32'h200);
        repeat (30) @(posedge clk); #1;

        // Asynchronous reset in the middle of S_X1
        send_line(32'h445566, 40, 41, 42, 43, 1'b1);
        wait_strobe(1, 50);
        #2;
        rst = 1'b1;
        abort_req++;
        #1;
        chk("arst_strobes", $countones({LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}), 0);
        chk("arst_point", LE_point, 0);
        chk("arst_color", LE_color, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_read(3'd7, rd); chk("arst_status", rd, 32'h200);
        repeat (20) @(posedge clk); #1;
        chk("arst_no_more", mon_phase, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/line_cmd_queue.md
Name: line_cmd_queue

Overview:
- Upstream feeder for the line engine: a CPU memory-mapped command port plus a small command FIFO and a sequencer.
- The CPU stages colour and endpoints in registers, then writes GO to enqueue a complete line command.
- The sequencer pops one command whenever the engine reports ready. It replays the command as one-cycle valid strobes (colour, x0, y0, x1, y1), followed by a single trigger pulse.
- Lets software queue several lines without polling LE_ready between them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, $clog2(DEPTH), FIFO pointer width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cpu_addr  in  3  word offset within the block
- cpu_din  in  32  write data
- cpu_we  in  1  write strobe
- cpu_re  in  1  read strobe
- cpu_dout  out  32  read data, registered
- busy  out  1  sequencer not idle, or FIFO not empty
- LE_ready  in  1  engine idle
- LE_color  out  32  colour, {8'b0, rgb24}
- LE_point  out  10  coordinate bus
- LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid  out  1 each  one-cycle strobes
- LE_trigger  out  1  one-cycle start pulse

Interface rule (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset: on rst assertion, immediately and without a clock edge:
  - all strobes and LE_trigger go to 0; LE_point = 0; LE_color = 0; cpu_dout = 0
  - staged registers = 0; FIFO empty; overflow = 0; state = S_IDLE
  - reset mid-sequence abandons the command; no partial trigger is issued.
- Register writes (cpu_we):
  - Offset 0 COLOR: stores din[23:0].
  - Offsets 1–4 X0/Y0/X1/Y1: store din[9:0]; upper bits ignored.
  - Offset 5 GO: pushes {color, x0, y0, x1, y1}. If the FIFO is full at the start of the cycle, the push is dropped and sticky overflow is set. A same-cycle pop does not make room.
  - Offset 6 CTRL: din[0] = 1 clears overflow. din[1] = 1 flushes all queued entries. An entry popped in the same cycle, or a sequence already in progress, completes normally.
  - Offset 7 is read-only; writes are ignored.
- Reads (cpu_re): cpu_dout updates on the next edge.
  - Offsets 0–4 return the staged value, zero-extended.
  - Offset 7 STATUS: [7:0] count, [8] full, [9] empty, [10] overflow, [11] busy, rest 0.
  - Other offsets return 0. cpu_dout holds its value when cpu_re = 0.
- FIFO:
  - Simultaneous push and pop are allowed when the FIFO is neither full nor empty; count is unchanged.
  - Pointers are AW+1 bits and wrap naturally.
- Sequencer states: S_IDLE, S_COLOR, S_X0, S_Y0, S_X1, S_Y1, S_TRIG, S_HOLD.
  - S_IDLE: if !empty && LE_ready, pop the head into an output holding register and go to S_COLOR; otherwise stay.
  - S_COLOR: LE_color_valid = 1; LE_color = {8'b0, color}.
  - S_X0 … S_Y1: the matching valid = 1 and LE_point = the matching coordinate; each lasts exactly one cycle.
  - S_TRIG: LE_trigger = 1.
  - S_HOLD: one guard cycle, covering the engine's ready deassertion after trigger; then S_IDLE.
  - All LE_* outputs are registered. LE_point = 0 outside S_X0..S_Y1. LE_color holds its last value.
  - At most one strobe is high in any cycle.
- Latency: with an empty FIFO and LE_ready = 1, GO written in cycle T gives:
  - pop at T+1
  - LE_color_valid at T+2
  - LE_x0_valid at T+3, LE_y0_valid at T+4, LE_x1_valid at T+5, LE_y1_valid at T+6
  - LE_trigger at T+7
- Minimum spacing between triggers is 8 cycles.
- LE_ready is sampled only in S_IDLE.

Decomposition:
- Package line_cmd_pkg:
  - register offset constants (COLOR..STATUS)
  - STATUS bit positions
  - state enum
  - packed entry struct (color 24, x0/y0/x1/y1 10 each; 64 bits)
- Sub-module cmd_fifo: synchronous FIFO, parameters WIDTH and DEPTH; ports push, pop, flush, dout, count, full, empty; async active-high reset.

Test Plan:
- Single line: write COLOR 0x00FF8040, X0 10, Y0 20, X1 100, Y1 50, GO at T, LE_ready = 1 → required response:
  - LE_color_valid at T+2 with LE_color 0x00FF8040
  - LE_point 10, 20, 100, 50 on T+3..T+6 with the matching valids
  - LE_trigger only at T+7
- Backpressure: hold LE_ready = 0 and queue 2 commands → STATUS count = 2, no strobes. Then raise LE_ready, with the model dropping it for 20 cycles after each trigger → second sequence starts only after ready returns; order is preserved.
- Overflow: DEPTH = 4, LE_ready = 0, five GOs → STATUS = count 4, full 1, overflow 1. Then CTRL 0x1 → overflow 0, count still 4.
- Truncation: X0 written 0xFFFFF3FF, COLOR written 0xAB123456 → LE_point 0x3FF, LE_color 0x00123456; read of offset 1 returns 0x3FF.
- Flush: 3 queued, first sequence at S_X0, write CTRL 0x2 → first sequence completes with trigger, count 0, no further strobes.
- Async reset: assert rst mid-S_X1 between clock edges → all strobes 0 immediately; after release, STATUS read = 0x200 (empty only).
